// File: rtl/seg_display_if.sv
// seg_display_if: display data inputs and scan outputs of seg_display_ctrl.
// Carries the optional bright input when SEG_DIMMING_EN is defined.
interface seg_display_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] num;
    logic                load;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blink_mask;
    logic                lz_blank;
`ifdef SEG_DIMMING_EN
    logic [3:0]          bright;
`endif
    logic [6:0]          LED;
    logic                dp;
    logic [DIGITS-1:0]   an;
    logic                frame_done;
    modport master (
`ifdef SEG_DIMMING_EN
        output bright,
`endif
        output num, load, dp_in, blink_mask, lz_blank,
        input  LED, dp, an, frame_done
    );
    modport slave (
`ifdef SEG_DIMMING_EN
        input  bright,
`endif
        input  num, load, dp_in, blink_mask, lz_blank,
        output LED, dp, an, frame_done
    );
endinterface

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: multiplexed 7-segment scanner with frame-atomic shadow data, blanking and blink.
// Define SEG_DIMMING_EN to add the 4-bit bright input for PWM dimming of the anodes.
module seg_display_ctrl #(
    parameter int DIGITS      = 4,
    parameter int SLOT_CYCLES = 262144,
    parameter int BLINK_SLOTS = 64
) (
    input logic       clk,
    input logic       rst,
    seg_display_if.slave bus
);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam int BW = BLINK_SLOTS > 1 ? $clog2(BLINK_SLOTS) : 1;
    localparam int SW = 6 * DIGITS;
    localparam logic [6:0] GLYPH [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [BW-1:0]       fcnt;
    logic                phase;
    logic [SW-1:0]       shadow, pend;
    logic                pend_v;
    logic [4*DIGITS-1:0] num_sh;
    logic [DIGITS-1:0]   dp_sh, bl_sh, zero_up;
    logic                slot_end, wrap, frame_flip, on, blank, z;
    logic [3:0]          nib;
    assign {bl_sh, dp_sh, num_sh} = shadow;
    assign slot_end   = cnt == CW'(SLOT_CYCLES - 1);
    assign wrap       = slot_end && idx == IW'(DIGITS - 1);
    assign frame_flip = fcnt == BW'(BLINK_SLOTS - 1);
    assign nib        = num_sh[{idx, 2'b00} +: 4];
    assign blank      = bus.lz_blank && idx != '0 && zero_up[idx];
`ifdef SEG_DIMMING_EN
    assign on = !(phase && bl_sh[idx]) && cnt[3:0] < bus.bright;
`else
    assign on = !(phase && bl_sh[idx]);
`endif
    // zero_up[i]: nibble i and every nibble above it are zero
    always_comb begin
        zero_up = '0;
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            z = z && num_sh[4*i +: 4] == 4'd0;
            zero_up[i] = z;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt            <= '0;
            idx            <= '0;
            fcnt           <= '0;
            phase          <= 1'b0;
            shadow         <= '0;
            pend           <= '0;
            pend_v         <= 1'b0;
            bus.an         <= '1;
            bus.LED        <= '1;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= wrap ? '0 : idx + 1'b1;
            if (wrap) begin
                fcnt   <= frame_flip ? '0 : fcnt + 1'b1;
                phase  <= phase ^ frame_flip;
                // a load on the wrap cycle itself is newest, so it wins over the pending copy
                shadow <= bus.load ? {bus.blink_mask, bus.dp_in, bus.num} : pend_v ? pend : shadow;
                pend_v <= 1'b0;
            end else if (bus.load) begin
                pend   <= {bus.blink_mask, bus.dp_in, bus.num};
                pend_v <= 1'b1;
            end
            bus.an         <= on ? ~(DIGITS'(1) << idx) : '1;
            bus.LED        <= blank ? '1 : GLYPH[nib];
            bus.dp         <= ~dp_sh[idx];
            bus.frame_done <= wrap;
        end
    end
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: directed literal checks plus randomized run against a positional model.
module tb_seg_display_ctrl;
    localparam int D  = 4;
    localparam int S  = 16;
    localparam int B  = 2;
    localparam int FR = S * D;
    localparam logic [6:0] GL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    int pos = -1;
    seg_display_if #(.DIGITS(D)) bus ();
    seg_display_ctrl #(.DIGITS(D), .SLOT_CYCLES(S), .BLINK_SLOTS(B)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s pos=%0d got=%0h want=%0h", name, pos, act, exp);
        end
    endtask
    // Model: outputs after an edge depend only on the position p since reset release
    logic [15:0]  cur_num, nxt_num;
    logic [D-1:0] cur_dp, cur_bl, nxt_dp, nxt_bl, e_an;
    logic         nxt_v, e_dp, e_fd, m_on;
    logic [6:0]   e_led;
    logic [3:0]   m_nib;
    int           p, m_idx, m_c, m_fr, zeros;
    always @(posedge clk) begin
        if (rst) begin
            pos = -1;
            cur_num = '0; cur_dp = '0; cur_bl = '0; nxt_v = 1'b0;
            e_an = '1; e_led = 7'h7f; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            p     = pos + 1;
            m_idx = (p / S) % D;
            m_c   = p % S;
            m_fr  = p / FR;
            m_on  = !(((m_fr / B) % 2 == 1) && cur_bl[m_idx]);
`ifdef SEG_DIMMING_EN
            m_on  = m_on && (m_c % 16) < int'(bus.bright);
`endif
            e_an  = m_on ? ~(D'(1) << m_idx) : '1;
            m_nib = 4'((cur_num >> (4 * m_idx)) & 16'hF);
            e_led = (bus.lz_blank && m_idx != 0 && (cur_num >> (4 * m_idx)) == 16'd0) ? 7'h7f : GL[m_nib];
            e_dp  = !cur_dp[m_idx];
            e_fd  = (p % FR) == FR - 1;
            if (bus.load) begin
                nxt_num = bus.num; nxt_dp = bus.dp_in; nxt_bl = bus.blink_mask; nxt_v = 1'b1;
            end
            if ((p % FR) == FR - 1 && nxt_v) begin
                cur_num = nxt_num; cur_dp = nxt_dp; cur_bl = nxt_bl; nxt_v = 1'b0;
            end
            pos = p;
        end
        #1;
        chk("an", 32'(bus.an), 32'(e_an));
        chk("LED", 32'(bus.LED), 32'(e_led));
        chk("dp", 32'(bus.dp), 32'(e_dp));
        chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
        zeros = 0;
        for (int i = 0; i < D; i++) zeros += bus.an[i] ? 0 : 1;
        chk("an_onehot", 32'(zeros <= 1), 32'd1);
    end
    task automatic goto(input int target);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (pos != target && n < 3000);
        if (pos != target) begin
            tests++; fails++;
            $display("FAIL goto_timeout got=%0d want=%0d", pos, target);
        end
    endtask
    initial begin
        bus.num = '0; bus.load = 1'b0; bus.dp_in = '0; bus.blink_mask = '0; bus.lz_blank = 1'b1;
`ifdef SEG_DIMMING_EN
        bus.bright = 4'd15;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_LED", 32'(bus.LED), 32'h7F);
        chk("rst_dp", 32'(bus.dp), 32'd1);
        chk("rst_fd", 32'(bus.frame_done), 32'd0);
        #1;
        rst = 1'b0; bus.load = 1'b1; bus.num = 16'h12AF;
        @(posedge clk); #2;
        bus.load = 1'b0;
        goto(5);
`ifndef SEG_DIMMING_EN
        chk("f0_d0_an", 32'(bus.an), 32'hE);
`endif
        chk("f0_d0_LED_old", 32'(bus.LED), 32'b0000001);
        goto(21);
        chk("f0_d1_lz", 32'(bus.LED), 32'h7F);
        goto(62);
        chk("fd_before", 32'(bus.frame_done), 32'd0);
        goto(63);
        chk("fd_last", 32'(bus.frame_done), 32'd1);
        goto(69);
        chk("f1_d0_LED", 32'(bus.LED), 32'b0111000);
`ifndef SEG_DIMMING_EN
        chk("f1_d0_an", 32'(bus.an), 32'hE);
`endif
        goto(82);
        chk("f1_d1_LED", 32'(bus.LED), 32'b0000010);
`ifndef SEG_DIMMING_EN
        chk("f1_d1_an", 32'(bus.an), 32'hD);
`endif
        #1;
        bus.load = 1'b1; bus.num = 16'h0040; bus.dp_in = 4'b0010; bus.blink_mask = 4'b0001;
        @(posedge clk); #2;
        bus.load = 1'b0;
        goto(101);
        chk("f1_d2_LED", 32'(bus.LED), 32'b0010010);
        goto(117);
        chk("f1_d3_LED", 32'(bus.LED), 32'b1001111);
        goto(133);
        chk("f2_d0_blink_off", 32'(bus.an), 32'hF);
        chk("f2_d0_LED", 32'(bus.LED), 32'b0000001);
        goto(149);
        chk("f2_d1_LED", 32'(bus.LED), 32'b1001100);
        chk("f2_d1_dp", 32'(bus.dp), 32'd0);
`ifndef SEG_DIMMING_EN
        chk("f2_d1_an", 32'(bus.an), 32'hD);
`endif
        goto(165);
        chk("f2_d2_blank", 32'(bus.LED), 32'h7F);
        goto(181);
        chk("f2_d3_blank", 32'(bus.LED), 32'h7F);
        goto(197);
        chk("f3_d0_blink_off", 32'(bus.an), 32'hF);
        goto(261);
`ifndef SEG_DIMMING_EN
        chk("f4_d0_blink_on", 32'(bus.an), 32'hE);
`endif
        goto(291);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_an", 32'(bus.an), 32'hF);
        #1;
        rst = 1'b0;
        goto(5);
`ifndef SEG_DIMMING_EN
        chk("after_rst_an", 32'(bus.an), 32'hE);
`endif
        chk("after_rst_LED", 32'(bus.LED), 32'b0000001);
        goto(21);
        chk("after_rst_shadow0", 32'(bus.LED), 32'h7F);
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #2;
            bus.load = ($urandom % 12) == 0;
            bus.num = ($urandom % 3 == 0) ? 16'($urandom % 256) : 16'($urandom);
            bus.dp_in = 4'($urandom);
            bus.blink_mask = 4'($urandom);
            if ($urandom % 64 == 0) bus.lz_blank = ~bus.lz_blank;
            rst = ($urandom % 400) == 0;
`ifdef SEG_DIMMING_EN
            if ($urandom % 100 == 0) bus.bright = 4'($urandom);
`endif
        end
        @(posedge clk); #2;
        rst = 1'b0; bus.load = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL provide parameter DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL provide parameter SLOT_CYCLES, default 262144: clock cycles each digit stays selected, minimum 16.
REQ-003 SHALL provide parameter BLINK_SLOTS, default 64: number of full scan frames per blink half-period, minimum 1.
REQ-004 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: num  in  4*DIGITS  hex nibbles; nibble i drives digit i, digit 0 is rightmost.
REQ-007 SHALL have ports: load  in  1  strobe; captures num, dp_in and blink_mask into the shadow register.
REQ-008 SHALL have ports: dp_in  in  DIGITS  decimal point per digit, 1=lit.
REQ-009 SHALL have ports: blink_mask  in  DIGITS  1=digit blinks.
REQ-010 SHALL have ports: lz_blank  in  1  1=suppress leading zeros.
REQ-011 SHALL have ports: LED  out  7  segments {a,b,c,d,e,f,g}, active-low.
REQ-012 SHALL have ports: dp  out  1  decimal point, active-low.
REQ-013 SHALL have ports: an  out  DIGITS  digit enables, active-low, one-hot-low.
REQ-014 SHALL have ports: frame_done  out  1  one-cycle pulse at the end of the last digit slot.

Function
REQ-015 SHALL count a slot counter 0..SLOT_CYCLES-1, then wrap to 0 and advance the digit index.
REQ-016 SHALL advance the digit index 0,1,..,DIGITS-1 and wrap to 0; DIGITS=1 keeps the index at 0.
REQ-017 SHALL drive an, LED and dp from registers; a digit-index change appears on the outputs exactly 1 cycle later.
REQ-018 SHALL decode nibbles 0-9 and A-F with hex glyphs; active-low patterns are: 0=0000001, 1=1001111, 8=0000000, F=0111000.
REQ-019 SHALL update the shadow register only at a frame boundary (digit index wraps to 0), using the most recent load strobe seen in that frame, so that no frame mixes old and new data.
REQ-020 SHALL apply the update at the same boundary when load coincides with the wrap cycle.
REQ-021 SHALL, with lz_blank=1, blank (LED=1111111) each digit that is zero and all of whose higher digits are also zero; digit 0 is never blanked; dp remains governed by dp_in.
REQ-022 SHALL toggle a blink phase every BLINK_SLOTS frames; during the off phase, digits with blink_mask=1 drive an high (off) for their slot.
REQ-023 SHALL pulse frame_done high for exactly the final cycle of slot DIGITS-1.
REQ-024 SHALL never drive more than one an bit low in any cycle, including across reset and wrap.

Reset
REQ-025 SHALL, while rst=1, set an to all ones, LED=1111111, dp=1, frame_done=0, counters and blink phase to 0 (on), and the shadow register to 0.
REQ-026 SHALL, in the first cycle after rst deasserts, start at digit 0, slot count 0; an=...1110 appears on the following cycle.
REQ-027 SHALL, if reset asserts mid-frame, discard any pending load.

Configuration
REQ-028 SHALL, with macro SEG_DIMMING_EN defined, add input bright (4 bits) and, within each slot, drive an low only while (slot counter mod 16) < bright; bright=0 keeps the display dark, bright=15 gives 15/16 duty.
REQ-029 SHALL, without SEG_DIMMING_EN, have no bright port and drive the selected an low for the whole slot.

Verification
REQ-030 SHALL cover: DIGITS=4, SLOT_CYCLES=16, load num=0x12AF -> an sequence 1110,1101,1011,0111, with LED=0111000,0000010,0010010,1001111 respectively.
REQ-031 SHALL cover: lz_blank=1, num=0x0040 -> digits 3 and 2 blank, digit 1 shows 4 (1001100), digit 0 shows 0 (0000001).
REQ-032 SHALL cover: load asserted mid-frame during digit 1 -> old data shown through digit 3, new data shown from the next digit 0.
REQ-033 SHALL cover: BLINK_SLOTS=2, blink_mask=0001 -> digit 0 anode off on frames 2,3,6,7 and on otherwise; other digits unaffected.
REQ-034 SHALL cover: rst pulsed during the digit 2 slot -> an=1111 during reset, restart at digit 0, shadow register=0.
REQ-035 SHALL cover, with SEG_DIMMING_EN defined: bright=4 -> an low for 4 of every 16 cycles within each slot; bright=0 -> an stays 1111.
